// File: rtl/pe_phase_sequencer.sv
// Three-phase burst sequencer for a PE triplet: steps phase 1->2->3 per beat,
// hands out the shared exact multiplier one-hot per phase, and counts committed beats.
module pe_phase_sequencer #(
    parameter int unsigned BEAT_W = 8
) (
    input  logic              fast_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BEAT_W-1:0] beats,
    input  logic              hold,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic [1:0]        phase,
    output logic [2:0]        exact_grant,
    output logic              beat_commit,
    output logic              result_valid,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [BEAT_W-1:0] ONE = BEAT_W'(1);

    state_e            state_q;
    logic [1:0]        ph_q;
    logic [BEAT_W-1:0] rem_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic              result_valid_q;

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ph_q           <= 2'd1;
            rem_q          <= '0;
            beat_cnt_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        beat_cnt_q <= '0;
                        ph_q       <= 2'd1;
                        if (beats != '0) begin
                            rem_q   <= beats;
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    // abort wins over both hold and the phase-3 commit
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (!hold) begin
                        if (ph_q == 2'd3) begin
                            rem_q          <= rem_q - ONE;
                            beat_cnt_q     <= beat_cnt_q + ONE;
                            result_valid_q <= 1'b1;
                            ph_q           <= 2'd1;
                            if (rem_q == ONE) begin
                                state_q <= S_DONE;
                            end
                        end else begin
                            ph_q <= ph_q + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ready       = (state_q == S_IDLE);
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        phase       = (busy && !hold) ? ph_q : 2'd0;
        beat_commit = (phase == 2'd3);
        exact_grant = 3'b000;
        unique case (phase)
            2'd1:    exact_grant = 3'b001;
            2'd2:    exact_grant = 3'b010;
            2'd3:    exact_grant = 3'b100;
            default: exact_grant = 3'b000;
        endcase
    end

    assign result_valid = result_valid_q;
    assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_pe_phase_sequencer.sv
// Directed bench for pe_phase_sequencer: burst timing, hold, abort, zero-beat,
// ignored starts and asynchronous reset, each against hand-computed tables.
module tb_pe_phase_sequencer;

    localparam int unsigned BEAT_W = 8;

    logic              fast_clk;
    logic              rst_n;
    logic              start;
    logic [BEAT_W-1:0] beats;
    logic              hold;
    logic              abort;
    logic              ready;
    logic              busy;
    logic [1:0]        phase;
    logic [2:0]        exact_grant;
    logic              beat_commit;
    logic              result_valid;
    logic [BEAT_W-1:0] beat_cnt;
    logic              done;

    int nchecks = 0;
    int nerr    = 0;

    pe_phase_sequencer #(.BEAT_W(BEAT_W)) dut (
        .fast_clk     (fast_clk),
        .rst_n        (rst_n),
        .start        (start),
        .beats        (beats),
        .hold         (hold),
        .abort        (abort),
        .ready        (ready),
        .busy         (busy),
        .phase        (phase),
        .exact_grant  (exact_grant),
        .beat_commit  (beat_commit),
        .result_valid (result_valid),
        .beat_cnt     (beat_cnt),
        .done         (done)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a cycle's inputs just after the rising edge, then sample mid-cycle.
    task automatic cyc(input logic h, input logic a, input logic s);
        @(posedge fast_clk);
        #1;
        hold  = h;
        abort = a;
        start = s;
        @(negedge fast_clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready"},  32'(ready), 32'd1);
        chk({tag, " busy"},   32'(busy), 32'd0);
        chk({tag, " phase"},  32'(phase), 32'd0);
        chk({tag, " grant"},  32'(exact_grant), 32'd0);
        chk({tag, " commit"}, 32'(beat_commit), 32'd0);
        chk({tag, " rv"},     32'(result_valid), 32'd0);
        chk({tag, " cnt"},    32'(beat_cnt), 32'd0);
        chk({tag, " done"},   32'(done), 32'd0);
    endtask

    int t1_ph[8]  = '{1, 2, 3, 1, 2, 3, 0, 0};
    int t1_gr[8]  = '{1, 2, 4, 1, 2, 4, 0, 0};
    int t1_rv[8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
    int t1_dn[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    int t1_rdy[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    int t2_hd[6] = '{0, 1, 1, 0, 0, 0};
    int t2_ph[6] = '{1, 0, 0, 2, 3, 0};
    int t2_gr[6] = '{1, 0, 0, 2, 4, 0};
    int t2_dn[6] = '{0, 0, 0, 0, 0, 1};

    int t3_ab[7] = '{0, 0, 0, 0, 0, 1, 0};
    int t3_ph[7] = '{1, 2, 3, 1, 2, 3, 0};
    int t3_rv[7] = '{0, 0, 0, 1, 0, 0, 0};

    int t5_st[10] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        beats = '0;
        hold  = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge fast_clk);
        @(negedge fast_clk);
        chk_reset_outputs("rst");

        // beats=2, no hold; start accepted on the first edge after release
        rst_n = 1'b1;
        start = 1'b1;
        beats = 8'd2;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("t1 phase c%0d", k + 1), 32'(phase), 32'(t1_ph[k]));
            chk($sformatf("t1 grant c%0d", k + 1), 32'(exact_grant), 32'(t1_gr[k]));
            chk($sformatf("t1 commit c%0d", k + 1), 32'(beat_commit), 32'(t1_ph[k] == 3));
            chk($sformatf("t1 rv c%0d", k + 1), 32'(result_valid), 32'(t1_rv[k]));
            chk($sformatf("t1 done c%0d", k + 1), 32'(done), 32'(t1_dn[k]));
            chk($sformatf("t1 ready c%0d", k + 1), 32'(ready), 32'(t1_rdy[k]));
            if (k == 6) chk("t1 beat_cnt", 32'(beat_cnt), 32'd2);
        end
        chk("t1 beat_cnt idle", 32'(beat_cnt), 32'd2);

        // beats=1 with a two-cycle hold while ph=2
        beats = 8'd1;
        cyc(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(t2_hd[k][0], 1'b0, 1'b0);
            chk($sformatf("t2 phase c%0d", k + 1), 32'(phase), 32'(t2_ph[k]));
            chk($sformatf("t2 grant c%0d", k + 1), 32'(exact_grant), 32'(t2_gr[k]));
            chk($sformatf("t2 done c%0d", k + 1), 32'(done), 32'(t2_dn[k]));
        end
        chk("t2 beat_cnt", 32'(beat_cnt), 32'd1);

        // beats=3, abort on the second ph=3 cycle
        beats = 8'd3;
        cyc(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0, t3_ab[k][0], 1'b0);
            chk($sformatf("t3 phase c%0d", k + 1), 32'(phase), 32'(t3_ph[k]));
            chk($sformatf("t3 rv c%0d", k + 1), 32'(result_valid), 32'(t3_rv[k]));
            chk($sformatf("t3 done c%0d", k + 1), 32'(done), 32'd0);
        end
        chk("t3 ready", 32'(ready), 32'd1);
        chk("t3 beat_cnt", 32'(beat_cnt), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3 done late", 32'(done), 32'd0);
        chk("t3 rv late", 32'(result_valid), 32'd0);

        // beats=0 goes straight to DONE
        beats = 8'd0;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4 done", 32'(done), 32'd1);
        chk("t4 phase", 32'(phase), 32'd0);
        chk("t4 busy", 32'(busy), 32'd0);
        chk("t4 ready", 32'(ready), 32'd0);
        chk("t4 beat_cnt", 32'(beat_cnt), 32'd0);
        chk("t4 rv", 32'(result_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4 ready after", 32'(ready), 32'd1);
        chk("t4 done after", 32'(done), 32'd0);
        chk("t4 rv after", 32'(result_valid), 32'd0);

        // start pulsed during RUN and during DONE must be ignored
        begin
            int act = 0;
            int dn  = 0;
            int rv  = 0;
            beats = 8'd2;
            cyc(1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 10; k++) begin
                cyc(1'b0, 1'b0, t5_st[k][0]);
                if (phase != 2'd0) act++;
                if (done) dn++;
                if (result_valid) rv++;
            end
            chk("t5 active phases", 32'(act), 32'd6);
            chk("t5 done pulses", 32'(dn), 32'd1);
            chk("t5 rv pulses", 32'(rv), 32'd2);
            chk("t5 ready", 32'(ready), 32'd1);
            chk("t5 beat_cnt", 32'(beat_cnt), 32'd2);
        end

        // start together with abort in IDLE is ignored
        beats = 8'd2;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6 ready", 32'(ready), 32'd1);
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 phase", 32'(phase), 32'd0);

        // abort beats hold
        beats = 8'd1;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t7 phase c1", 32'(phase), 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t7 phase held", 32'(phase), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t7 ready", 32'(ready), 32'd1);
        chk("t7 phase", 32'(phase), 32'd0);
        chk("t7 done", 32'(done), 32'd0);

        // asynchronous reset mid-burst at ph=2 of the second beat
        beats = 8'd2;
        cyc(1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        chk("t8 pre phase", 32'(phase), 32'd2);
        chk("t8 pre beat_cnt", 32'(beat_cnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t8 async");
        start = 1'b1;
        beats = 8'd1;
        @(negedge fast_clk);
        chk_reset_outputs("t8 held");
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("t8 phase c1", 32'(phase), 32'd1);
        chk("t8 busy c1", 32'(busy), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t8 phase c2", 32'(phase), 32'd2);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t8 phase c3", 32'(phase), 32'd3);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t8 done c4", 32'(done), 32'd1);
        chk("t8 rv c4", 32'(result_valid), 32'd1);
        chk("t8 beat_cnt c4", 32'(beat_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
